// File: rtl/tty_pkg.sv
// tty_pkg: device codes, IOT op codes and printer FSM states shared by the TTY controller.
package tty_pkg;
    localparam logic [2:0] IOT_OP  = 3'd6;
    localparam logic [5:0] DEV_KBD = 6'o03;
    localparam logic [5:0] DEV_PRT = 6'o04;

    typedef enum logic [2:0] {
        KCF = 3'd0,
        KSF = 3'd1,
        KCC = 3'd2,
        KRS = 3'd4,
        KIE = 3'd5,
        KRB = 3'd6
    } kbd_op_e;

    typedef enum logic [2:0] {
        SPF = 3'd0,
        TSF = 3'd1,
        TCF = 3'd2,
        TPC = 3'd4,
        SPI = 3'd5,
        TLS = 3'd6
    } prt_op_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        BUSY       = 2'd2
    } prt_state_e;
endpackage

// File: rtl/tty_ctrl_if.sv
// tty_ctrl_if: CPU IOT bus and UART handshake signals of the TTY controller.
interface tty_ctrl_if;
    logic        ioStb;
    logic [11:0] ioInstr;
    logic [11:0] acIn;
    logic        ioDone;
    logic        skip;
    logic        acClr;
    logic [11:0] acOr;
    logic        irq;
    logic [7:0]  txData;
    logic        txStb;
    logic        txRdy;
    logic [7:0]  rxData;
    logic        rxAck;
    logic        rxRdy;

    modport master (
        output ioStb, ioInstr, acIn, txRdy, rxData, rxRdy,
        input  ioDone, skip, acClr, acOr, irq, txData, txStb, rxAck
    );

    modport slave (
        input  ioStb, ioInstr, acIn, txRdy, rxData, rxRdy,
        output ioDone, skip, acClr, acOr, irq, txData, txStb, rxAck
    );
endinterface

// File: rtl/tty_baudgen.sv
// tty_baudgen: one-CLK baudX7 tick every CLK_HZ/(BAUD*7) clocks.
module tty_baudgen #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic CLK,
    input  logic RESET,
    output logic baudX7
);
    localparam int DIV = CLK_HZ / (BAUD * 7);
    localparam int W   = $clog2(DIV);

    logic [W-1:0] cnt;
    logic         wrap;

    assign wrap = cnt == W'(DIV - 1);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt    <= '0;
            baudX7 <= 1'b0;
        end else begin
            cnt    <= wrap ? '0 : cnt + W'(1);
            baudX7 <= wrap;
        end
    end
endmodule

// File: rtl/tty_ctrl.sv
// tty_ctrl: PDP-8 style keyboard/printer IOT decoder with receive capture,
// printer handshake FSM, one-deep send pending register and interrupt request.
module tty_ctrl
    import tty_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 9600
) (
    input  logic       CLK,
    input  logic       RESET,
    tty_ctrl_if.slave  bus,
    output logic       baudX7,
    output logic       kbdOverrun
);
    prt_state_e  state, state_nx;
    logic        kbd_flag, prt_flag, ie, rx_prev, rx_arm, pend;
    logic [7:0]  kbd_buf, pend_char, req_char;
    logic [2:0]  op;
    logic        iot, kbd_sel, prt_sel, rx_rise;
    logic        kbd_clr, ovr_clr, prt_set, prt_clr;
    logic        send_req, req_valid, issue;
    logic        skip_nx, clr_nx;
    logic [11:0] or_nx;
    logic        unused_ok;

    tty_baudgen #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_baudgen (
        .CLK   (CLK),
        .RESET (RESET),
        .baudX7(baudX7)
    );

    assign unused_ok = ^bus.acIn[11:8];
    assign op        = bus.ioInstr[2:0];
    assign iot       = bus.ioStb & (bus.ioInstr[11:9] == IOT_OP);
    assign kbd_sel   = iot & (bus.ioInstr[8:3] == DEV_KBD);
    assign prt_sel   = iot & (bus.ioInstr[8:3] == DEV_PRT);

    always_comb begin
        // rx_arm masks an rxRdy that is already high when reset releases
        rx_rise   = rx_arm & bus.rxRdy & ~rx_prev;
        kbd_clr   = kbd_sel & (op == KCF || op == KCC || op == KRB);
        ovr_clr   = kbd_sel & (op == KCC || op == KRB);
        prt_clr   = prt_sel & (op == TCF || op == TLS);
        send_req  = prt_sel & (op == TPC || op == TLS);
        req_valid = send_req | pend;
        req_char  = send_req ? bus.acIn[7:0] : pend_char;
        issue     = req_valid & (state == IDLE) & bus.txRdy;
        prt_set   = (prt_sel & (op == SPF)) | ((state == BUSY) & bus.txRdy);
        skip_nx   = (kbd_sel & (op == KSF) & kbd_flag) |
                    (prt_sel & (op == TSF) & prt_flag) |
                    (prt_sel & (op == SPI) & bus.irq);
        clr_nx    = ovr_clr;
        or_nx     = (kbd_sel & (op == KRS || op == KRB)) ? {4'b0, kbd_buf} : 12'd0;
        state_nx  = state;
        if (issue)
            state_nx = WAIT_START;
        else if (state == WAIT_START && !bus.txRdy)
            state_nx = BUSY;
        else if (state == BUSY && bus.txRdy)
            state_nx = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            kbd_flag   <= 1'b0;
            prt_flag   <= 1'b0;
            kbdOverrun <= 1'b0;
            kbd_buf    <= '0;
            ie         <= 1'b1;
            rx_prev    <= 1'b0;
            rx_arm     <= 1'b0;
            pend       <= 1'b0;
            pend_char  <= '0;
            bus.txData <= '0;
            bus.txStb  <= 1'b0;
            bus.rxAck  <= 1'b0;
            bus.irq    <= 1'b0;
            bus.ioDone <= 1'b0;
            bus.skip   <= 1'b0;
            bus.acClr  <= 1'b0;
            bus.acOr   <= '0;
        end else begin
            rx_prev    <= bus.rxRdy;
            rx_arm     <= 1'b1;
            bus.rxAck  <= rx_rise;
            if (rx_rise)
                kbd_buf <= bus.rxData;
            // sets take priority over same-cycle clears
            kbd_flag   <= rx_rise | (kbd_flag & ~kbd_clr);
            kbdOverrun <= (rx_rise & kbd_flag) | (kbdOverrun & ~ovr_clr);
            prt_flag   <= prt_set | (prt_flag & ~prt_clr);
            if (kbd_sel && op == KIE)
                ie <= bus.acIn[0];
            pend       <= req_valid & ~issue;
            if (req_valid && !issue)
                pend_char <= req_char;
            if (issue)
                bus.txData <= req_char;
            bus.txStb  <= issue;
            bus.irq    <= ie & (kbd_flag | prt_flag);
            bus.ioDone <= kbd_sel | prt_sel;
            bus.skip   <= skip_nx;
            bus.acClr  <= clr_nx;
            bus.acOr   <= or_nx;
        end
    end
endmodule

// File: tb/tb_tty_ctrl.sv
// tb_tty_ctrl: scoreboard bench for tty_ctrl with a busy-for-N-clocks UART transmitter model.
module tb_tty_ctrl;
    typedef struct packed {
        logic        skip;
        logic        clr;
        logic [11:0] acor;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud, ovr;
    int         checks = 0;
    int         errors = 0;
    int         busy = 0;
    int         busy_len = 5;
    resp_t      io_q[$];
    logic [7:0] tx_q[$];
    resp_t      exp_r, got_r;
    logic [7:0] exp_tx;

    tty_ctrl_if bus();

    tty_ctrl #(.CLK_HZ(700), .BAUD(10)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .bus       (bus),
        .baudX7    (baud),
        .kbdOverrun(ovr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // IOT response scoreboard
    always @(negedge clk) begin
        if (bus.ioDone === 1'b1) begin
            checks++;
            if (io_q.size() == 0) begin
                errors++;
                $display("FAIL io_unexpected ioDone with no request");
            end else begin
                exp_r = io_q.pop_front();
                got_r = {bus.skip, bus.acClr, bus.acOr};
                if (got_r !== exp_r) begin
                    errors++;
                    $display("FAIL io_resp got skip=%b clr=%b acOr=%o expected skip=%b clr=%b acOr=%o",
                             got_r.skip, got_r.clr, got_r.acor, exp_r.skip, exp_r.clr, exp_r.acor);
                end
            end
        end else if (!rst) begin
            checks++;
            if ({bus.skip, bus.acClr, bus.acOr} !== 14'd0) begin
                errors++;
                $display("FAIL io_idle skip=%b clr=%b acOr=%o expected zero", bus.skip, bus.acClr, bus.acOr);
            end
        end
    end

    // transmitter model and tx scoreboard
    always @(negedge clk) begin
        if (bus.txStb === 1'b1) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected txData=%h expected no txStb", bus.txData);
            end else begin
                exp_tx = tx_q.pop_front();
                if (bus.txData !== exp_tx) begin
                    errors++;
                    $display("FAIL tx_data got %h expected %h", bus.txData, exp_tx);
                end
            end
            busy = busy_len;
        end
        if (busy > 0) begin
            bus.txRdy = 1'b0;
            busy--;
        end else
            bus.txRdy = 1'b1;
    end

    task automatic iot(input logic [11:0] instr, input logic [11:0] ac,
                       input logic s, input logic c, input logic [11:0] o);
        io_q.push_back({s, c, o});
        @(negedge clk);
        bus.ioStb   = 1'b1;
        bus.ioInstr = instr;
        bus.acIn    = ac;
        @(negedge clk);
        bus.ioStb = 1'b0;
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rxData = b;
        bus.rxRdy  = 1'b1;
        @(negedge clk);
        bus.rxRdy = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.ioStb   = 1'b1;
        bus.ioInstr = 12'o6031;
        bus.acIn    = 12'd0;
        bus.rxData  = 8'h5A;
        bus.rxRdy   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.ioDone, bus.skip, bus.acClr, bus.acOr, bus.txStb, bus.rxAck, bus.irq, baud, ovr, bus.txData} !== 28'd0) begin
            errors++;
            $display("FAIL reset_during outputs=%h expected 0",
                     {bus.ioDone, bus.skip, bus.acClr, bus.acOr, bus.txStb, bus.rxAck, bus.irq, baud, ovr, bus.txData});
        end
        rst = 1'b0;
        bus.ioStb = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.ioDone, bus.skip, bus.acClr, bus.acOr, bus.txStb, bus.rxAck, bus.irq, baud} !== 19'd0) begin
            errors++;
            $display("FAIL reset_after outputs=%h expected 0",
                     {bus.ioDone, bus.skip, bus.acClr, bus.acOr, bus.txStb, bus.rxAck, bus.irq, baud});
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rxAck !== 1'b0) begin
                errors++;
                $display("FAIL reset_rx_high rxAck=%b expected 0", bus.rxAck);
            end
        end
        bus.rxRdy = 1'b0;
        iot(12'o6031, 12'd0, 1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_baud();
        int first = 0;
        int gap = 0;
        apply_reset();
        for (int k = 2; k <= 30 && first == 0; k++) begin
            @(negedge clk);
            if (baud === 1'b1) first = k;
        end
        checks++;
        if (first !== 10) begin
            errors++;
            $display("FAIL baud_first got %0d clocks expected 10", first);
        end
        for (int k = 1; k <= 30 && gap == 0; k++) begin
            @(negedge clk);
            if (baud === 1'b1) gap = k;
        end
        checks++;
        if (gap !== 10) begin
            errors++;
            $display("FAIL baud_period got %0d clocks expected 10", gap);
        end
    endtask

    task automatic test_receive();
        rx_byte(8'h41);
        checks++;
        if ({bus.rxAck, bus.irq} !== 2'b10) begin
            errors++;
            $display("FAIL rx_ack rxAck,irq=%b expected 10", {bus.rxAck, bus.irq});
        end
        @(negedge clk);
        checks++;
        if ({bus.rxAck, bus.irq} !== 2'b01) begin
            errors++;
            $display("FAIL rx_irq rxAck,irq=%b expected 01", {bus.rxAck, bus.irq});
        end
        iot(12'o6031, 12'd0, 1'b1, 1'b0, 12'd0);
        iot(12'o6036, 12'd0, 1'b0, 1'b1, 12'h041);
        iot(12'o6031, 12'd0, 1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_overrun();
        rx_byte(8'h12);
        rx_byte(8'h34);
        @(negedge clk);
        checks++;
        if (ovr !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set kbdOverrun=%b expected 1", ovr);
        end
        iot(12'o6034, 12'd0, 1'b0, 1'b0, 12'h034);
        iot(12'o6032, 12'd0, 1'b0, 1'b1, 12'd0);
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clr kbdOverrun=%b expected 0", ovr);
        end
        iot(12'o6031, 12'd0, 1'b0, 1'b0, 12'd0);
        rx_byte(8'h56);
        repeat (2) @(negedge clk);
        iot(12'o6045, 12'd0, 1'b1, 1'b0, 12'd0);
        iot(12'o6035, 12'd0, 1'b0, 1'b0, 12'd0);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL kie_mask irq=%b expected 0", bus.irq);
        end
        iot(12'o6045, 12'd0, 1'b0, 1'b0, 12'd0);
        iot(12'o6035, 12'd1, 1'b0, 1'b0, 12'd0);
        iot(12'o6036, 12'd0, 1'b0, 1'b1, 12'h056);
    endtask

    task automatic test_kbd_race();
        io_q.push_back({1'b0, 1'b0, 12'd0});
        @(negedge clk);
        bus.rxData  = 8'h22;
        bus.rxRdy   = 1'b1;
        bus.ioStb   = 1'b1;
        bus.ioInstr = 12'o6030;
        @(negedge clk);
        bus.ioStb = 1'b0;
        bus.rxRdy = 1'b0;
        checks++;
        if (bus.rxAck !== 1'b1) begin
            errors++;
            $display("FAIL race_ack rxAck=%b expected 1", bus.rxAck);
        end
        #1;
        iot(12'o6031, 12'd0, 1'b1, 1'b0, 12'd0);
        iot(12'o6036, 12'd0, 1'b0, 1'b1, 12'h022);
        iot(12'o6033, 12'd0, 1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_other_dev();
        logic [11:0] bad [3] = '{12'o6054, 12'o5031, 12'o6004};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.ioStb   = 1'b1;
            bus.ioInstr = bad[i];
            @(negedge clk);
            bus.ioStb = 1'b0;
            checks++;
            if (bus.ioDone !== 1'b0) begin
                errors++;
                $display("FAIL other_dev instr=%o ioDone=%b expected 0", bad[i], bus.ioDone);
            end
        end
        checks++;
        if (io_q.size() != 0) begin
            errors++;
            $display("FAIL io_missing %0d responses outstanding expected 0", io_q.size());
        end
    endtask

    task automatic test_print();
        tx_q.push_back(8'hC3);
        iot(12'o6046, 12'h0C3, 1'b0, 1'b0, 12'd0);
        checks++;
        if (bus.txStb !== 1'b1) begin
            errors++;
            $display("FAIL tls_stb txStb=%b expected 1", bus.txStb);
        end
        repeat (10) @(negedge clk);
        checks++;
        if ({bus.txData, bus.irq} !== {8'hC3, 1'b1}) begin
            errors++;
            $display("FAIL tx_hold txData,irq=%h expected %h", {bus.txData, bus.irq}, {8'hC3, 1'b1});
        end
        iot(12'o6041, 12'd0, 1'b1, 1'b0, 12'd0);
        iot(12'o6042, 12'd0, 1'b0, 1'b0, 12'd0);
        iot(12'o6041, 12'd0, 1'b0, 1'b0, 12'd0);
        iot(12'o6040, 12'd0, 1'b0, 1'b0, 12'd0);
        iot(12'o6041, 12'd0, 1'b1, 1'b0, 12'd0);
        iot(12'o6042, 12'd0, 1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_pending();
        busy_len = 20;
        tx_q.push_back(8'h55);
        tx_q.push_back(8'h66);
        iot(12'o6044, 12'h055, 1'b0, 1'b0, 12'd0);
        iot(12'o6044, 12'h066, 1'b0, 1'b0, 12'd0);
        repeat (50) @(negedge clk);
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL pend_two %0d chars unsent expected 0", tx_q.size());
        end
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h77);
        iot(12'o6044, 12'h011, 1'b0, 1'b0, 12'd0);
        iot(12'o6044, 12'h066, 1'b0, 1'b0, 12'd0);
        iot(12'o6044, 12'h077, 1'b0, 1'b0, 12'd0);
        repeat (50) @(negedge clk);
        checks++;
        if (tx_q.size() != 0) begin
            errors++;
            $display("FAIL pend_replace %0d chars unsent expected 0", tx_q.size());
        end
        iot(12'o6042, 12'd0, 1'b0, 1'b0, 12'd0);
    endtask

    task automatic test_reset_busy();
        iot(12'o6040, 12'd0, 1'b0, 1'b0, 12'd0);
        tx_q.push_back(8'h99);
        iot(12'o6044, 12'h099, 1'b0, 1'b0, 12'd0);
        iot(12'o6044, 12'h0AA, 1'b0, 1'b0, 12'd0);
        repeat (3) @(negedge clk);
        apply_reset();
        repeat (40) @(negedge clk);
        checks++;
        if (tx_q.size() != 0 || bus.txRdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_busy queue=%0d txRdy=%b expected 0 and 1", tx_q.size(), bus.txRdy);
        end
        iot(12'o6041, 12'd0, 1'b0, 1'b0, 12'd0);
        checks++;
        if (bus.irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy_irq irq=%b expected 0", bus.irq);
        end
        busy_len = 5;
    endtask

    initial begin
        test_reset();
        test_baud();
        test_receive();
        test_overrun();
        test_kbd_race();
        test_other_dev();
        test_print();
        test_pending();
        test_reset_busy();
        repeat (3) @(negedge clk);
        checks++;
        if (io_q.size() != 0 || tx_q.size() != 0) begin
            errors++;
            $display("FAIL drain io=%0d tx=%0d expected 0 and 0", io_q.size(), tx_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
